vga_rx_monitor: RTL

Receive-side checker for the VGA port: samples the same hsync/vsync/RGB lines the display generator drives and recovers pixel position and frame lock from the sync pulses. Timing and line/frame-length errors are flagged, and one probed pixel's colour is captured per frame. It sits beside the display path on the board clock and feeds debug LEDs, the seven-segment debug mux and the self-test bench. No feedback into the generator.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/vga_rx_monitor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing shared with the display generator, plus monitor types.
package vga_pkg;

  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_TOTAL  = 525;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } mon_state_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank; resets to the idle (high) level of the VGA syncs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages, both preset to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA checker: recovers position and frame lock from the syncs,
// flags bad line/frame lengths and captures one probed pixel per frame.
module vga_rx_monitor
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_red0,
  input  logic        vga_green0,
  input  logic        vga_blue0,
  input  logic [10:0] probe_x,
  input  logic [9:0]  probe_y,
  output logic [10:0] px_x,
  output logic [9:0]  px_y,
  output logic        px_valid,
  output logic        locked,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic [7:0]  frame_cnt,
  output logic [2:0]  probe_rgb,
  output logic        probe_vld
);

  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_STOP  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_STOP  = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_LEN   = 12'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);

  logic [4:0]  sync_q;
  logic        s_h, s_v;
  rgb3         s_rgb, rgb_q;
  logic        h_prev, v_prev;
  logic        h_fall, v_fall;
  logic [10:0] hcnt, hcnt_nx;
  logic [9:0]  vcnt, vcnt_nx;
  logic        h_seen;
  logic        hlen_bad, vlen_bad, frame_inc;
  logic        in_active;
  mon_state_t  state, state_nx;

  sync_2ff #(.WIDTH(5)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({vga_hsync, vga_vsync, vga_red0, vga_green0, vga_blue0}),
    .q     (sync_q)
  );

  assign s_h    = sync_q[4];
  assign s_v    = sync_q[3];
  assign s_rgb  = sync_q[2:0];
  assign h_fall = pix_en & h_prev & ~s_h;
  assign v_fall = pix_en & v_prev & ~s_v;

  // Counter next values and length checks against the pre-edge counts.
  always_comb begin
    hcnt_nx  = hcnt;
    vcnt_nx  = vcnt;
    hlen_bad = h_fall && (state != SEARCH) && h_seen && (({1'b0, hcnt} + 12'd1) != H_LEN);
    vlen_bad = v_fall && (state != SEARCH) && (({1'b0, vcnt} + 11'd1) != V_LEN);
    if (pix_en) begin
      if (h_fall)           hcnt_nx = '0;
      else if (hcnt != '1)  hcnt_nx = hcnt + 11'd1;
      if (v_fall)                     vcnt_nx = '0;
      else if (h_fall && vcnt != '1)  vcnt_nx = vcnt + 10'd1;
    end
    in_active = (state_nx == LOCKED) && (hcnt_nx >= H_START) && (hcnt_nx < H_STOP)
                && (vcnt_nx >= V_START) && (vcnt_nx < V_STOP);
  end

  // Lock FSM next state; an error always wins over a vsync edge in the same strobe.
  always_comb begin
    state_nx  = state;
    frame_inc = 1'b0;
    case (state)
      SEARCH: if (v_fall) state_nx = ACQUIRE;
      ACQUIRE, LOCKED: begin
        if (hlen_bad || vlen_bad) begin
          state_nx = SEARCH;
        end else if (v_fall) begin
          state_nx  = LOCKED;
          frame_inc = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // Edge history and position counters advance only on pixel strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_prev <= 1'b1;
      v_prev <= 1'b1;
      hcnt   <= '0;
      vcnt   <= '0;
    end else if (pix_en) begin
      h_prev <= s_h;
      v_prev <= s_v;
      hcnt   <= hcnt_nx;
      vcnt   <= vcnt_nx;
    end
  end

  // FSM state, lock flag, error pulses and good-frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      h_seen    <= 1'b0;
      locked    <= 1'b0;
      err_hlen  <= 1'b0;
      err_vlen  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nx;
      locked    <= (state_nx == LOCKED);
      err_hlen  <= hlen_bad;
      err_vlen  <= vlen_bad;
      frame_cnt <= frame_cnt + {7'd0, frame_inc};
      if (state_nx == SEARCH && state != SEARCH) h_seen <= 1'b0;
      else if (h_fall)                           h_seen <= 1'b1;
    end
  end

  // Registered active-area position, tagged with the colour of the same sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_x     <= '0;
      px_y     <= '0;
      px_valid <= 1'b0;
      rgb_q    <= '0;
    end else if (pix_en) begin
      px_x     <= hcnt_nx - H_START;
      px_y     <= vcnt_nx - V_START;
      px_valid <= in_active;
      rgb_q    <= s_rgb;
    end
  end

  // Probe capture uses the registered position so the colour matches that pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_rgb <= '0;
      probe_vld <= 1'b0;
    end else if (pix_en && px_valid && px_x == probe_x && px_y == probe_y) begin
      probe_rgb <= rgb_q;
      probe_vld <= 1'b1;
    end
  end

endmodule
